// File: rtl/rx_ram_wr_responder_pkg.sv
// Shared definitions for the receiver RAM-write responder: widths, write FSM states, status bit positions.
// No logic of its own; sat_inc16 is the saturating counter step used for accepted-byte counting.
// Backpressure: not applicable.
package rx_ram_wr_responder_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_REL  = 2'd3
  } wr_state_t;

  // msg_status = {line, right, len_err, addr_err}
  localparam int STAT_ADDR_ERR = 0;
  localparam int STAT_LEN_ERR  = 1;
  localparam int STAT_RIGHT    = 2;
  localparam int STAT_LINE     = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_msg_buffer_dpram.sv
// Message byte buffer: one write port, one registered read port, maps to block RAM.
// Read latency 1 cycle; read-during-write to the same address returns the old byte.
// Backpressure: none, both ports accept every cycle.
module rx_msg_buffer_dpram
  import rx_ram_wr_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_h,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register is reset; array contents are left undefined.
  always_ff @(posedge clk) begin
    if (rst_h) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_ram_wr_responder.sv
// Responder for RAM_REQ_WR/RAM_RDY_WR byte writes into a message buffer, plus host-side message handoff.
// Request to ram_rdy_wr takes WR_LATENCY+2 cycles; host read data arrives 1 cycle after host_rd_addr.
// Never stalls the receiver: writes that cannot be stored are still acknowledged and flagged.
module rx_ram_wr_responder
  import rx_ram_wr_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_h,
  input  logic                  ram_req_wr,
  input  logic [ADDR_W-1:0]     ram_addr_in,
  input  logic [DATA_W-1:0]     ram_data_in,
  output logic                  ram_rdy_wr,
  input  logic                  rx_flag_number_rd_en,
  input  logic [7:0]            rx_flag,
  input  logic [15:0]           rx_byte_number,
  input  logic                  rx_end_message,
  input  logic                  rx_message_right,
  input  logic                  rx_end_message_line,
  output logic                  msg_valid,
  output logic [7:0]            msg_flag,
  output logic [15:0]           msg_len,
  output logic [3:0]            msg_status,
  input  logic                  msg_ack,
  output logic                  overflow,
  input  logic [DEPTH_LOG2-1:0] host_rd_addr,
  output logic [DATA_W-1:0]     host_rd_data
);

  localparam logic [2:0] WAIT_LAST = 3'(WR_LATENCY);

  wr_state_t         state;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  logic [7:0]  hdr_flag;
  logic [15:0] hdr_count;
  logic [15:0] acc_cnt;
  logic        addr_err;
  logic        dropped;

  logic        in_ack;
  logic        addr_oob;
  logic        wr_en;
  logic        wr_drop;
  logic [15:0] acc_cnt_nx;
  logic        addr_err_nx;
  logic        ack_take;
  logic        end_drop;
  logic [3:0]  status_nx;

  assign in_ack   = (state == ST_ACK);
  assign addr_oob = |cap_addr[ADDR_W-1:DEPTH_LOG2];
  // While the host owns the buffer nothing may be overwritten; the message is marked dropped instead.
  assign wr_drop  = in_ack && msg_valid;
  assign wr_en    = in_ack && !addr_oob && !msg_valid;

  // "_nx" values fold in the write completing this cycle so a coincident end counts it.
  assign acc_cnt_nx  = wr_en ? sat_inc16(acc_cnt) : acc_cnt;
  assign addr_err_nx = addr_err | (in_ack & addr_oob);
  assign ack_take    = msg_ack & msg_valid;
  assign end_drop    = dropped | wr_drop | (msg_valid & ~msg_ack);

  always_comb begin
    status_nx                = '0;
    status_nx[STAT_LINE]     = rx_end_message_line;
    status_nx[STAT_RIGHT]    = rx_message_right;
    status_nx[STAT_LEN_ERR]  = (acc_cnt_nx != hdr_count);
    status_nx[STAT_ADDR_ERR] = addr_err_nx;
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      cap_addr   <= '0;
      cap_data   <= '0;
      ram_rdy_wr <= 1'b0;
    end else begin
      ram_rdy_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ram_req_wr) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
            cap_addr <= ram_addr_in;
            cap_data <= ram_data_in;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state      <= ST_ACK;
            ram_rdy_wr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_ACK: state <= ST_REL;
        // A request still held after the ack must not be taken as a second write.
        ST_REL: if (!ram_req_wr) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      hdr_flag   <= '0;
      hdr_count  <= '0;
      acc_cnt    <= '0;
      addr_err   <= 1'b0;
      dropped    <= 1'b0;
      msg_valid  <= 1'b0;
      msg_flag   <= '0;
      msg_len    <= '0;
      msg_status <= '0;
      overflow   <= 1'b0;
    end else begin
      if (rx_flag_number_rd_en) begin
        hdr_flag  <= rx_flag;
        hdr_count <= rx_byte_number;
        acc_cnt   <= '0;
        addr_err  <= 1'b0;
        dropped   <= 1'b0;
      end else begin
        acc_cnt  <= acc_cnt_nx;
        addr_err <= addr_err_nx;
        dropped  <= dropped | wr_drop;
      end

      if (ack_take) msg_valid <= 1'b0;

      // Ack is applied first, so an end in the same cycle can still publish a new message.
      if (rx_end_message) begin
        if (end_drop) begin
          overflow <= 1'b1;
        end else begin
          msg_valid  <= 1'b1;
          msg_flag   <= hdr_flag;
          msg_len    <= acc_cnt_nx;
          msg_status <= status_nx;
        end
      end
    end
  end

  rx_msg_buffer_dpram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_buf (
    .clk     (clk),
    .rst_h   (rst_h),
    .wr_en   (wr_en),
    .wr_addr (cap_addr[DEPTH_LOG2-1:0]),
    .wr_data (cap_data),
    .rd_addr (host_rd_addr),
    .rd_data (host_rd_data)
  );

endmodule

// File: tb/tb_rx_ram_wr_responder.sv
// Bench for rx_ram_wr_responder: directed handshake scenarios plus random messages vs a message-level model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_rx_ram_wr_responder;

  localparam int DL    = 10;
  localparam int WL    = 3;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_h = 1'b1;
  logic          ram_req_wr = 1'b0;
  logic [15:0]   ram_addr_in = '0;
  logic [7:0]    ram_data_in = '0;
  logic          ram_rdy_wr;
  logic          rx_flag_number_rd_en = 1'b0;
  logic [7:0]    rx_flag = '0;
  logic [15:0]   rx_byte_number = '0;
  logic          rx_end_message = 1'b0;
  logic          rx_message_right = 1'b0;
  logic          rx_end_message_line = 1'b0;
  logic          msg_valid;
  logic [7:0]    msg_flag;
  logic [15:0]   msg_len;
  logic [3:0]    msg_status;
  logic          msg_ack = 1'b0;
  logic          overflow;
  logic [DL-1:0] host_rd_addr = '0;
  logic [7:0]    host_rd_data;

  always #5 clk = ~clk;

  rx_ram_wr_responder #(.DEPTH_LOG2(DL), .WR_LATENCY(WL)) dut (
    .clk(clk), .rst_h(rst_h),
    .ram_req_wr(ram_req_wr), .ram_addr_in(ram_addr_in), .ram_data_in(ram_data_in),
    .ram_rdy_wr(ram_rdy_wr),
    .rx_flag_number_rd_en(rx_flag_number_rd_en), .rx_flag(rx_flag), .rx_byte_number(rx_byte_number),
    .rx_end_message(rx_end_message), .rx_message_right(rx_message_right),
    .rx_end_message_line(rx_end_message_line),
    .msg_valid(msg_valid), .msg_flag(msg_flag), .msg_len(msg_len), .msg_status(msg_status),
    .msg_ack(msg_ack), .overflow(overflow),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data)
  );

  int checks = 0;
  int errors = 0;
  int rdy_hi = 0;

  always @(negedge clk) if (ram_rdy_wr === 1'b1) rdy_hi++;

  // Message-level reference state
  bit          m_valid, m_ovf;
  logic [7:0]  m_flag;
  logic [15:0] m_len;
  logic [3:0]  m_status;
  logic [7:0]  mem_m [DEPTH];
  bit          mem_ok [DEPTH];
  logic [7:0]  cur_flag;
  logic [15:0] cur_decl;
  int          cur_cnt;
  bit          cur_aerr, cur_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_ovf = 0; m_flag = '0; m_len = '0; m_status = '0;
    cur_flag = '0; cur_decl = '0; cur_cnt = 0; cur_aerr = 0; cur_drop = 0;
    for (int i = 0; i < DEPTH; i++) mem_ok[i] = 0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (int'(a) >= DEPTH) cur_aerr = 1;
    else if (m_valid) cur_drop = 1;
    else begin
      mem_m[a[DL-1:0]] = d;
      mem_ok[a[DL-1:0]] = 1;
      if (cur_cnt < 65535) cur_cnt++;
    end
  endtask

  task automatic model_end(input bit right, input bit line, input bit ack);
    if (ack) m_valid = 0;
    if (cur_drop || m_valid) m_ovf = 1;
    else begin
      m_valid  = 1;
      m_flag   = cur_flag;
      m_len    = 16'(cur_cnt);
      m_status = {line, right, (cur_cnt != int'(cur_decl)), cur_aerr};
    end
  endtask

  task automatic do_header(input logic [7:0] f, input logic [15:0] n);
    rx_flag = f; rx_byte_number = n; rx_flag_number_rd_en = 1'b1;
    step();
    rx_flag_number_rd_en = 1'b0;
    cur_flag = f; cur_decl = n; cur_cnt = 0; cur_aerr = 0; cur_drop = 0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (ram_rdy_wr !== 1'b1 && lat < 50);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    int lat;
    ram_addr_in = a; ram_data_in = d; ram_req_wr = 1'b1;
    wait_rdy(lat);
    chk("wr_latency", 32'(lat), 32'(WL + 2));
    ram_req_wr = 1'b0;
    step();
    step();
    model_write(a, d);
  endtask

  task automatic do_end(input bit right, input bit line, input bit ack);
    rx_message_right = right; rx_end_message_line = line;
    rx_end_message = 1'b1; msg_ack = ack;
    step();
    rx_end_message = 1'b0; msg_ack = 1'b0;
    model_end(right, line, ack);
  endtask

  task automatic do_ack();
    msg_ack = 1'b1;
    step();
    msg_ack = 1'b0;
    m_valid = 0;
  endtask

  task automatic check_msg(input string t);
    chk({t, ".valid"},    32'(msg_valid),  32'(m_valid));
    chk({t, ".flag"},     32'(msg_flag),   32'(m_flag));
    chk({t, ".len"},      32'(msg_len),    32'(m_len));
    chk({t, ".status"},   32'(msg_status), 32'(m_status));
    chk({t, ".overflow"}, 32'(overflow),   32'(m_ovf));
  endtask

  task automatic check_mem(input string t, input int a);
    host_rd_addr = DL'(a);
    step();
    chk(t, 32'(host_rd_data), 32'(mem_m[a]));
  endtask

  task automatic check_reset_outputs(input string t);
    chk({t, ".rdy"},      32'(ram_rdy_wr),   0);
    chk({t, ".valid"},    32'(msg_valid),    0);
    chk({t, ".flag"},     32'(msg_flag),     0);
    chk({t, ".len"},      32'(msg_len),      0);
    chk({t, ".status"},   32'(msg_status),   0);
    chk({t, ".overflow"}, 32'(overflow),     0);
    chk({t, ".rd_data"},  32'(host_rd_data), 0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, lat, first_rdy, n, a;
    logic [7:0] d0, d1;
    logic [15:0] ad;
    int addrs[$];

    model_reset();
    step(); step();
    check_reset_outputs("reset");
    rst_h = 1'b0;
    step();

    // 1) four in-range writes, correct length
    p0 = rdy_hi;
    do_header(8'h5A, 16'd4);
    for (int i = 0; i < 4; i++) do_write(16'(i), 8'hA0 + 8'(i));
    chk("t1.rdy_pulses", 32'(rdy_hi - p0), 4);
    do_end(1'b1, 1'b0, 1'b0);
    check_msg("t1");
    chk("t1.len_const", 32'(msg_len), 4);
    chk("t1.status_const", 32'(msg_status), 32'h4);
    for (int i = 0; i < 4; i++) check_mem("t1.rd", i);
    do_ack();
    chk("t1.ack_valid", 32'(msg_valid), 0);

    // 2) request held 20 cycles -> single ack, single write
    do_header(8'h11, 16'd1);
    d0 = 8'($urandom);
    p0 = rdy_hi; first_rdy = 0;
    ram_addr_in = 16'd10; ram_data_in = d0; ram_req_wr = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (ram_rdy_wr === 1'b1 && first_rdy == 0) first_rdy = c;
    end
    ram_req_wr = 1'b0;
    step(); step();
    model_write(16'd10, d0);
    chk("t2.first_rdy", 32'(first_rdy), 32'(WL + 2));
    chk("t2.rdy_cycles", 32'(rdy_hi - p0), 1);
    do_end(1'b1, 1'b1, 1'b0);
    check_msg("t2");
    check_mem("t2.rd", 10);
    do_ack();

    // 3) out-of-range address: acked, not written
    do_header(8'h22, 16'd1);
    do_write(16'h0400, 8'hEE);
    do_end(1'b1, 1'b0, 1'b0);
    check_msg("t3");
    chk("t3.status_const", 32'(msg_status), 32'h7);
    check_mem("t3.rd0", 0);
    do_ack();

    // 4) second message ends while first still owned by host
    d0 = 8'($urandom); d1 = 8'($urandom);
    do_header(8'h33, 16'd2);
    do_write(16'd20, d0);
    do_write(16'd21, d1);
    do_end(1'b0, 1'b1, 1'b0);
    do_header(8'h44, 16'd2);
    do_write(16'd20, ~d0);
    do_write(16'd21, ~d1);
    do_end(1'b1, 1'b0, 1'b0);
    check_msg("t4");
    chk("t4.overflow_const", 32'(overflow), 1);
    check_mem("t4.rd20", 20);
    check_mem("t4.rd21", 21);

    // 5) ack coincident with end: new message takes over
    do_header(8'h55, 16'd2);
    do_end(1'b0, 1'b1, 1'b1);
    check_msg("t5");
    chk("t5.status_const", 32'(msg_status), 32'hA);
    do_ack();

    // write completing in the same cycle as the end pulse
    do_header(8'h66, 16'd2);
    d0 = 8'($urandom); d1 = 8'($urandom);
    do_write(16'd30, d0);
    ram_addr_in = 16'd31; ram_data_in = d1; ram_req_wr = 1'b1;
    wait_rdy(lat);
    chk("t7.wr_latency", 32'(lat), 32'(WL + 2));
    rx_message_right = 1'b1; rx_end_message_line = 1'b0; rx_end_message = 1'b1;
    step();
    rx_end_message = 1'b0; ram_req_wr = 1'b0;
    step(); step();
    model_write(16'd31, d1);
    model_end(1'b1, 1'b0, 1'b0);
    check_msg("t7");
    check_mem("t7.rd31", 31);
    do_ack();

    // random messages
    for (int m = 0; m < 8; m++) begin
      n = $urandom_range(0, 5);
      addrs.delete();
      do_header(8'($urandom), 16'(($urandom_range(0, 2) == 0) ? n + 1 : n));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) ad = 16'(DEPTH + $urandom_range(0, 60000));
        else begin
          a = $urandom_range(0, DEPTH - 1);
          ad = 16'(a);
          addrs.push_back(a);
        end
        do_write(ad, 8'($urandom));
      end
      do_end(1'($urandom), 1'($urandom), 1'b0);
      check_msg("rnd");
      foreach (addrs[i]) check_mem("rnd.rd", addrs[i]);
      do_ack();
      chk("rnd.ack_valid", 32'(msg_valid), 0);
    end

    // 6) reset while the handshake is in WAIT
    chk("t6.overflow_before", 32'(overflow), 32'(m_ovf));
    do_header(8'h77, 16'd1);
    ram_addr_in = 16'd40; ram_data_in = 8'h99; ram_req_wr = 1'b1;
    step(); step();
    p0 = rdy_hi;
    rst_h = 1'b1; ram_req_wr = 1'b0;
    step();
    check_reset_outputs("t6.rst");
    step();
    rst_h = 1'b0;
    model_reset();
    repeat (6) step();
    chk("t6.no_rdy", 32'(rdy_hi - p0), 0);
    d0 = 8'($urandom);
    do_header(8'h88, 16'd1);
    do_write(16'd7, d0);
    do_end(1'b1, 1'b1, 1'b0);
    check_msg("t6.after");
    check_mem("t6.rd7", 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
